// File: rtl/shift_scheduler.sv
// shift_scheduler
//   Sequences the bucket-shift sweep engine. A down-counter times each sweep
//   period; when it expires the scheduler waits for the engine to report its
//   previous sweep finished, then issues a one-cycle watchdog pulse and
//   advances the (cur_bucket, cur_loop) pair the engine loads on restart.
//   Sweeps that are still running when the period expires are counted as
//   overruns.
//
// Ports
//   clk              in   clock
//   reset            in   asynchronous, active-high reset
//   sched_enable     in   1 = run periodic scheduling
//   period           in   cycles between fire attempts (0 behaves as 1)
//   sweep_done       in   level, 1 while the engine idles awaiting the watchdog
//   watchdog_signal  out  1-cycle pulse: restart sweep
//   cur_bucket       out  bucket index for the next sweep
//   cur_loop         out  loop index for the next sweep
//   epoch_tick       out  1-cycle pulse when cur_bucket wraps to 0
//   overrun_cnt      out  saturating count of late sweeps
//   busy             out  1 whenever the scheduler is not idle
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | scheduling disabled, bucket/loop/overrun held
// RUN   | counting down the sweep period
// FIRE  | period expired, waiting for sweep_done to issue the pulse
// HOLD  | pulse issued, waiting for the engine to drop sweep_done
module shift_scheduler #(
    parameter int PERIOD_WIDTH = 32,
    parameter int NUM_BUCKETS  = 14,
    parameter int BITS_SHIFT   = 4,
    parameter int LOOP_WIDTH   = 12,
    parameter int OVR_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sched_enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    sweep_done,
    output logic                    watchdog_signal,
    output logic [BITS_SHIFT-1:0]   cur_bucket,
    output logic [LOOP_WIDTH-1:0]   cur_loop,
    output logic                    epoch_tick,
    output logic [OVR_WIDTH-1:0]    overrun_cnt,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIRE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [BITS_SHIFT-1:0] LAST_BUCKET = BITS_SHIFT'(NUM_BUCKETS - 1);

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [BITS_SHIFT-1:0]   bucket_q, bucket_d;
    logic [LOOP_WIDTH-1:0]   loop_q, loop_d;
    logic [OVR_WIDTH-1:0]    ovr_q, ovr_d;
    logic                    ovr_seen_q, ovr_seen_d;
    logic                    wd_q, wd_d;
    logic                    epoch_q, epoch_d;
    logic                    busy_q, busy_d;
    logic [PERIOD_WIDTH-1:0] reload_val;

    // A zero period behaves like a period of one so the counter never underflows.
    assign reload_val = (period == '0) ? '0 : period - PERIOD_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bucket_d   = bucket_q;
        loop_d     = loop_q;
        ovr_d      = ovr_q;
        ovr_seen_d = ovr_seen_q;
        wd_d       = 1'b0;
        epoch_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sched_enable) begin
                    state_d = S_RUN;
                    cnt_d   = reload_val;
                end
            end
            S_RUN: begin
                if (!sched_enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d    = S_FIRE;
                    ovr_seen_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - PERIOD_WIDTH'(1);
                end
            end
            S_FIRE: begin
                if (sweep_done) begin
                    wd_d    = 1'b1;
                    state_d = S_HOLD;
                    if (bucket_q == LAST_BUCKET) begin
                        bucket_d = '0;
                        loop_d   = loop_q + LOOP_WIDTH'(1);
                        epoch_d  = 1'b1;
                    end else begin
                        bucket_d = bucket_q + BITS_SHIFT'(1);
                    end
                end else if (!ovr_seen_q) begin
                    // Only the first waiting cycle of a late sweep counts.
                    ovr_seen_d = 1'b1;
                    if (ovr_q != {OVR_WIDTH{1'b1}}) begin
                        ovr_d = ovr_q + OVR_WIDTH'(1);
                    end
                end
            end
            S_HOLD: begin
                if (!sweep_done) begin
                    if (sched_enable) begin
                        state_d = S_RUN;
                        cnt_d   = reload_val;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bucket_q   <= '0;
            loop_q     <= '0;
            ovr_q      <= '0;
            ovr_seen_q <= 1'b0;
            wd_q       <= 1'b0;
            epoch_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bucket_q   <= bucket_d;
            loop_q     <= loop_d;
            ovr_q      <= ovr_d;
            ovr_seen_q <= ovr_seen_d;
            wd_q       <= wd_d;
            epoch_q    <= epoch_d;
            busy_q     <= busy_d;
        end
    end

    assign watchdog_signal = wd_q;
    assign cur_bucket      = bucket_q;
    assign cur_loop        = loop_q;
    assign epoch_tick      = epoch_q;
    assign overrun_cnt     = ovr_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed bench for shift_scheduler. A second instance with a 1-bit loop
// index and 2-bit overrun counter shares all inputs so loop wrap and overrun
// saturation are reachable in a short run.
module tb_shift_scheduler;

    logic        clk;
    logic        reset;
    logic        sched_enable;
    logic [31:0] period;
    logic        sweep_done;

    logic        watchdog_signal, epoch_tick, busy;
    logic [3:0]  cur_bucket;
    logic [11:0] cur_loop;
    logic [15:0] overrun_cnt;

    logic        wd_s, epoch_s, busy_s;
    logic [3:0]  bucket_s;
    logic [0:0]  loop_s;
    logic [1:0]  ovr_s;

    int checks = 0;
    int errors = 0;

    shift_scheduler dut (
        .clk(clk), .reset(reset), .sched_enable(sched_enable), .period(period),
        .sweep_done(sweep_done), .watchdog_signal(watchdog_signal), .cur_bucket(cur_bucket),
        .cur_loop(cur_loop), .epoch_tick(epoch_tick), .overrun_cnt(overrun_cnt), .busy(busy)
    );

    shift_scheduler #(.LOOP_WIDTH(1), .OVR_WIDTH(2)) dut_s (
        .clk(clk), .reset(reset), .sched_enable(sched_enable), .period(period),
        .sweep_done(sweep_done), .watchdog_signal(wd_s), .cur_bucket(bucket_s),
        .cur_loop(loop_s), .epoch_tick(epoch_s), .overrun_cnt(ovr_s), .busy(busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (bounded) for a pulse, captures the outputs at it, then performs the
    // engine handshake: drop sweep_done for one cycle and raise it again.
    task automatic run_fire(input int max_cyc, output int gap, output bit seen,
                            output logic [3:0] b, output logic [11:0] l, output logic e,
                            output logic [0:0] l_s, output logic e_s, output logic wd_after);
        gap  = 0;
        seen = 0;
        while (!seen && gap < max_cyc) begin
            @(negedge clk);
            gap++;
            if (watchdog_signal === 1'b1) seen = 1;
        end
        b = cur_bucket; l = cur_loop; e = epoch_tick; l_s = loop_s; e_s = epoch_s;
        sweep_done = 1'b0;
        @(negedge clk);
        wd_after = watchdog_signal;
        sweep_done = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; sched_enable = 1'b0; period = 32'd4; sweep_done = 1'b1;
        @(negedge clk);
        checks++;
        if ({watchdog_signal, cur_bucket, cur_loop, epoch_tick, overrun_cnt, busy} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state got wd=%b b=%0d l=%0d e=%b o=%0d busy=%b want all 0",
                     watchdog_signal, cur_bucket, cur_loop, epoch_tick, overrun_cnt, busy);
        end
    endtask

    task automatic test_basic;
        int gap; bit seen; logic [3:0] b; logic [11:0] l; logic e, e_s, wda; logic [0:0] l_s;
        reset = 1'b0; sched_enable = 1'b1; period = 32'd4; sweep_done = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            run_fire(50, gap, seen, b, l, e, l_s, e_s, wda);
            checks++;
            if (!seen) begin errors++; $display("FAIL basic_timeout fire %0d got none want pulse", k); end
            checks++;
            if (gap !== ((k == 1) ? 6 : 5)) begin
                errors++; $display("FAIL basic_gap fire %0d got %0d want %0d", k, gap, (k == 1) ? 6 : 5);
            end
            checks++;
            if (b !== 4'(k) || l !== 12'd0 || e !== 1'b0) begin
                errors++; $display("FAIL basic_bucket fire %0d got b=%0d l=%0d e=%b want b=%0d l=0 e=0", k, b, l, e, k);
            end
            checks++;
            if (wda !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b want 0", wda); end
        end
    endtask

    // Fires 4..14 on the main loop index; fire 14 wraps the bucket.
    task automatic test_epoch_wrap;
        int gap; bit seen; logic [3:0] b; logic [11:0] l; logic e, e_s, wda; logic [0:0] l_s;
        for (int k = 4; k <= 14; k++) begin
            run_fire(50, gap, seen, b, l, e, l_s, e_s, wda);
            checks++;
            if (!seen || gap !== 5) begin
                errors++; $display("FAIL epoch_gap fire %0d got seen=%0d gap=%0d want 1 5", k, seen, gap);
            end
            checks++;
            if (b !== 4'(k % 14) || l !== 12'(k / 14) || e !== (k == 14)) begin
                errors++; $display("FAIL epoch_state fire %0d got b=%0d l=%0d e=%b want b=%0d l=%0d e=%b",
                                   k, b, l, e, k % 14, k / 14, k == 14);
            end
            checks++;
            if (wda !== 1'b0) begin errors++; $display("FAIL epoch_pulse_width got %b want 0", wda); end
        end
    endtask

    // Fires 15..28: the 1-bit loop index on the second instance wraps from all-ones to 0.
    task automatic test_loop_wrap;
        int gap; bit seen; logic [3:0] b; logic [11:0] l; logic e, e_s, wda; logic [0:0] l_s;
        for (int k = 15; k <= 28; k++) begin
            run_fire(50, gap, seen, b, l, e, l_s, e_s, wda);
            checks++;
            if (!seen || gap !== 5) begin
                errors++; $display("FAIL loopwrap_gap fire %0d got seen=%0d gap=%0d want 1 5", k, seen, gap);
            end
            checks++;
            if (b !== 4'(k % 14) || l !== 12'(k / 14) || l_s !== 1'((k / 14) % 2) || e_s !== (k == 28)) begin
                errors++; $display("FAIL loopwrap_state fire %0d got b=%0d l=%0d ls=%b es=%b want b=%0d l=%0d ls=%0d es=%b",
                                   k, b, l, l_s, e_s, k % 14, k / 14, (k / 14) % 2, k == 28);
            end
        end
    endtask

    task automatic test_overrun;
        sweep_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (watchdog_signal !== 1'b0) begin errors++; $display("FAIL overrun_no_pulse cyc %0d got 1 want 0", i); end
        end
        checks++;
        if (overrun_cnt !== 16'd1 || ovr_s !== 2'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL overrun_count got %0d/%0d busy=%b want 1/1 busy=1", overrun_cnt, ovr_s, busy);
        end
        sweep_done = 1'b1;
        @(negedge clk);
        checks++;
        if (watchdog_signal !== 1'b1 || cur_bucket !== 4'd1 || cur_loop !== 12'd2) begin
            errors++; $display("FAIL overrun_late_fire got wd=%b b=%0d l=%0d want 1 1 2", watchdog_signal, cur_bucket, cur_loop);
        end
        sweep_done = 1'b0;
        @(negedge clk);
        checks++;
        if (watchdog_signal !== 1'b0) begin errors++; $display("FAIL overrun_pulse_width got 1 want 0"); end
        // Now in RUN: disabling returns to IDLE keeping bucket/loop/overrun.
        sched_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cur_bucket !== 4'd1 || cur_loop !== 12'd2 || overrun_cnt !== 16'd1) begin
            errors++; $display("FAIL disable_idle got busy=%b b=%0d l=%0d o=%0d want 0 1 2 1",
                               busy, cur_bucket, cur_loop, overrun_cnt);
        end
    endtask

    // period=0 with late sweeps: each round is RUN, FIRE, overrun, wait, then a fire.
    task automatic test_period_zero_saturate;
        period = 32'd0; sched_enable = 1'b1;
        for (int r = 0; r < 4; r++) begin
            sweep_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checks++;
                if (watchdog_signal !== 1'b0) begin errors++; $display("FAIL p0_no_pulse round %0d cyc %0d got 1 want 0", r, i); end
            end
            sweep_done = 1'b1;
            @(negedge clk);
            checks++;
            if (watchdog_signal !== 1'b1) begin errors++; $display("FAIL p0_fire round %0d got 0 want 1", r); end
        end
        checks++;
        if (overrun_cnt !== 16'd5 || ovr_s !== 2'd3) begin
            errors++; $display("FAIL p0_saturate got %0d/%0d want 5/3", overrun_cnt, ovr_s);
        end
        checks++;
        if (cur_bucket !== 4'd5 || cur_loop !== 12'd2) begin
            errors++; $display("FAIL p0_bucket got b=%0d l=%0d want 5 2", cur_bucket, cur_loop);
        end
    endtask

    task automatic test_reset_mid;
        int gap; bit seen; logic [3:0] b; logic [11:0] l; logic e, e_s, wda; logic [0:0] l_s;
        // sweep_done still high: scheduler parks in HOLD.
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || watchdog_signal !== 1'b0) begin errors++; $display("FAIL hold_busy got busy=%b wd=%b want 1 0", busy, watchdog_signal); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({watchdog_signal, cur_bucket, cur_loop, epoch_tick, overrun_cnt, busy, ovr_s} !== 37'd0) begin
            errors++; $display("FAIL reset_in_hold got b=%0d l=%0d o=%0d busy=%b want all 0", cur_bucket, cur_loop, overrun_cnt, busy);
        end
        period = 32'd4; sweep_done = 1'b0; sched_enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || overrun_cnt !== 16'd1) begin
            errors++; $display("FAIL fire_wait got busy=%b o=%0d want 1 1", busy, overrun_cnt);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({watchdog_signal, cur_bucket, cur_loop, epoch_tick, overrun_cnt, busy} !== 35'd0) begin
            errors++; $display("FAIL reset_in_fire got o=%0d busy=%b want 0 0", overrun_cnt, busy);
        end
        sweep_done = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_fire(50, gap, seen, b, l, e, l_s, e_s, wda);
        checks++;
        if (!seen || gap !== 6 || b !== 4'd1 || l !== 12'd0) begin
            errors++; $display("FAIL post_reset_fire got seen=%0d gap=%0d b=%0d l=%0d want 1 6 1 0", seen, gap, b, l);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_epoch_wrap;
        test_loop_wrap;
        test_overrun;
        test_period_zero_saturate;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
